// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status into the controller, stall/flush/forward controls out.
// Latency: none, pure wiring; timing belongs to the modules on each side.
// Backpressure: none carried here; stall lines are the pipeline's backpressure.
// Ports: master = pipeline side (drives register ids and events); slave = hazard_ctrl side.
interface hazard_ctrl_if;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [4:0]  rdE;
    logic        loadE;
    logic [4:0]  rdM;
    logic [4:0]  rdW;
    logic        regWriteM;
    logic        regWriteW;
    logic        pcSrcE;
    logic        mduStartE;
    logic        mduDone;
    logic        imemReady;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        flushD;
    logic        flushE;
    logic        flushM;
    logic [1:0]  forwardAE;
    logic [1:0]  forwardBE;
    logic [31:0] stallCycles;
    logic [31:0] flushCount;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, loadE, rdM, rdW,
               regWriteM, regWriteW, pcSrcE, mduStartE, mduDone, imemReady,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
               forwardAE, forwardBE, stallCycles, flushCount
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, loadE, rdM, rdW,
               regWriteM, regWriteW, pcSrcE, mduStartE, mduDone, imemReady,
        output stallF, stallD, stallE, flushD, flushE, flushM,
               forwardAE, forwardBE, stallCycles, flushCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: stall/flush for IF/ID, ID/EX, EX/MEM, EX forwarding selects,
// post-reset drain, MDU wait and imem wait sequencing, saturating stall/flush counters.
// Latency: controls are combinational from state and inputs; state/counters update at posedge clk.
// Backpressure: stallF/stallD/stallE hold the front of the pipe; flush* squash instructions as NOPs.
// Ports: clk, rst (async, active-high), hz (hazard_ctrl_if.slave).
module hazard_ctrl #(
    parameter int RESET_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_RUN      = 2'd1,
        S_MDU_WAIT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]   stall_cnt_q, flush_cnt_q;

    logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic load_use, mdu_stall, branch_flush;

    // A load writing x0 never creates a dependency.
    assign load_use  = hz.loadE && (hz.rdE != 5'd0) &&
                       ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
    // Start and done in the same cycle means the MDU answered immediately: no stall.
    assign mdu_stall = hz.mduStartE && !hz.mduDone;
    assign branch_flush = (state_q == S_RUN) && hz.pcSrcE;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // A taken branch squashes the MDU op in E, so it never starts a wait.
                if (!hz.pcSrcE && mdu_stall) begin
                    state_d = S_MDU_WAIT;
                end
            end
            S_MDU_WAIT: begin
                if (hz.mduDone) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    // Output logic: RUN rules are prioritised branch > MDU > load-use > imem wait.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        case (state_q)
            S_HOLD: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
            S_RUN: begin
                if (hz.pcSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (mdu_stall) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                end else if (load_use) begin
                    // Holding D also holds the pending fetch, so imem wait needs no extra action.
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end else if (!hz.imemReady) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
            end
            S_MDU_WAIT: begin
                // E is released on the done cycle; a branch still in E is held, not taken.
                if (!hz.mduDone) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                end
            end
            default: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
        endcase
    end

    // Forwarding: the younger result in M wins over W; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // Performance counters, saturating; drain cycles in HOLD are not stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q != S_HOLD) && stall_f && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (branch_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stallF      = stall_f;
    assign hz.stallD      = stall_d;
    assign hz.stallE      = stall_e;
    assign hz.flushD      = flush_d;
    assign hz.flushE      = flush_e;
    assign hz.flushM      = flush_m;
    assign hz.forwardAE   = fwd_sel(hz.rs1E, hz.regWriteM, hz.rdM, hz.regWriteW, hz.rdW);
    assign hz.forwardBE   = fwd_sel(hz.rs2E, hz.regWriteM, hz.rdM, hz.regWriteW, hz.rdW);
    assign hz.stallCycles = stall_cnt_q;
    assign hz.flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then randomized traffic against a behavioural model.
// Latency: outputs checked on the negedge; model advances on each posedge.
// Backpressure: not applicable; the bench drives every input each cycle.
module tb_hazard_ctrl;

    localparam int RC = 2;

    logic clk;
    logic rst;
    hazard_ctrl_if hz();

    hazard_ctrl #(.RESET_CYCLES(RC)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: mode 0 = draining after reset, 1 = running, 2 = waiting on MDU.
    int     m_mode;
    int     m_held;
    longint m_stalls;
    longint m_flushes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {stallF, stallD, stallE, flushD, flushE, flushM}.
    function automatic logic [5:0] exp_ctrl();
        logic lu;
        lu = hz.loadE && hz.rdE != 0 && (hz.rdE == hz.rs1D || hz.rdE == hz.rs2D);
        if (m_mode == 0) return 6'b100110;
        if (m_mode == 2) return hz.mduDone ? 6'b000000 : 6'b111001;
        if (hz.pcSrcE) return 6'b000110;
        if (hz.mduStartE && !hz.mduDone) return 6'b111001;
        if (lu) return 6'b110010;
        if (!hz.imemReady) return 6'b100100;
        return 6'b000000;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (hz.regWriteM && hz.rdM != 0 && hz.rdM == rs) return 2'b10;
        if (hz.regWriteW && hz.rdW != 0 && hz.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] sat(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "/ctrl"}, {26'd0, hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.flushM},
            {26'd0, exp_ctrl()});
        chk({tag, "/fwdA"}, {30'd0, hz.forwardAE}, {30'd0, exp_fwd(hz.rs1E)});
        chk({tag, "/fwdB"}, {30'd0, hz.forwardBE}, {30'd0, exp_fwd(hz.rs2E)});
        chk({tag, "/stallCycles"}, hz.stallCycles, sat(m_stalls));
        chk({tag, "/flushCount"}, hz.flushCount, sat(m_flushes));
    endtask

    // Called at posedge+1 with inputs already set for this cycle.
    task automatic cycle(input string tag);
        logic [5:0] e;
        @(negedge clk);
        check_all(tag);
        e = exp_ctrl();
        @(posedge clk);
        if (m_mode != 0 && e[5]) m_stalls++;
        case (m_mode)
            0: begin
                m_held++;
                if (m_held == RC) m_mode = 1;
            end
            1: begin
                if (hz.pcSrcE) m_flushes++;
                else if (hz.mduStartE && !hz.mduDone) m_mode = 2;
            end
            default: if (hz.mduDone) m_mode = 1;
        endcase
        #1;
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_held    = 0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // Asynchronous reset mid-cycle; released just after the next posedge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle_inputs();
        hz.rs1D = 0; hz.rs2D = 0; hz.rs1E = 0; hz.rs2E = 0; hz.rdE = 0;
        hz.loadE = 0; hz.rdM = 0; hz.rdW = 0; hz.regWriteM = 0; hz.regWriteW = 0;
        hz.pcSrcE = 0; hz.mduStartE = 0; hz.mduDone = 0; hz.imemReady = 1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Post-reset drain
        cycle("hold0");
        cycle("hold1");
        cycle("run_idle");

        // Load-use on rs1, then the load moves on
        hz.loadE = 1; hz.rdE = 5; hz.rs1D = 5;
        cycle("loaduse");
        hz.loadE = 0;
        cycle("loaduse_after");
        // Load into x0 never stalls
        hz.loadE = 1; hz.rdE = 0; hz.rs1D = 0;
        cycle("loaduse_x0");
        // Load-use on rs2 while imem waits: load-use wins
        hz.rdE = 9; hz.rs2D = 9; hz.imemReady = 0;
        cycle("loaduse_imem");

        // Taken branch beats load-use and imem wait
        hz.pcSrcE = 1;
        cycle("branch");
        idle_inputs();
        cycle("branch_after");

        // MDU with done three cycles after start
        hz.mduStartE = 1;
        cycle("mdu_start");
        hz.mduStartE = 0;
        cycle("mdu_wait1");
        hz.pcSrcE = 1;
        cycle("mdu_wait2_br");
        hz.pcSrcE = 0; hz.mduDone = 1; hz.mduStartE = 1;
        cycle("mdu_done");
        idle_inputs();
        cycle("mdu_after");
        // Start and done together: no stall
        hz.mduStartE = 1; hz.mduDone = 1;
        cycle("mdu_same");
        idle_inputs();

        // Instruction-memory wait for four cycles
        hz.imemReady = 0;
        for (int i = 0; i < 4; i++) cycle("imem_wait");
        hz.imemReady = 1;
        cycle("imem_ready");

        // Forwarding priority
        hz.rdM = 7; hz.rdW = 7; hz.regWriteM = 1; hz.regWriteW = 1; hz.rs1E = 7; hz.rs2E = 7;
        cycle("fwd_m");
        hz.regWriteM = 0;
        cycle("fwd_w");
        hz.rdM = 0; hz.rdW = 0; hz.regWriteM = 1;
        cycle("fwd_x0");
        idle_inputs();

        // Reset in the middle of an MDU wait
        hz.mduStartE = 1;
        cycle("mdu_pre_rst");
        hz.mduStartE = 0;
        do_reset("reset_mdu");
        cycle("hold0b");

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("reset_rand");
            hz.rs1D      = 5'($urandom_range(0, 7));
            hz.rs2D      = 5'($urandom_range(0, 7));
            hz.rs1E      = 5'($urandom_range(0, 7));
            hz.rs2E      = 5'($urandom_range(0, 7));
            hz.rdE       = 5'($urandom_range(0, 7));
            hz.rdM       = 5'($urandom_range(0, 7));
            hz.rdW       = 5'($urandom_range(0, 7));
            hz.loadE     = ($urandom_range(0, 2) == 0);
            hz.regWriteM = 1'($urandom_range(0, 1));
            hz.regWriteW = 1'($urandom_range(0, 1));
            hz.pcSrcE    = ($urandom_range(0, 6) == 0);
            hz.mduStartE = ($urandom_range(0, 6) == 0) && !hz.pcSrcE;
            hz.mduDone   = ($urandom_range(0, 3) == 0);
            hz.imemReady = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. Generates the stall/flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers and the EX-stage forwarding selects, and sequences three conditions: the post-reset pipeline drain, multi-cycle MDU operations and instruction-memory wait states. It also keeps saturating stall and flush performance counters.

## Interface
- RESET_CYCLES, 2, cycles the pipeline is held flushed after reset deasserts (≥1)
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- rs1D, rs2D  in  5  source registers of the instruction in D
- rs1E, rs2E, rdE  in  5  sources and destination of the instruction in E
- loadE  in  1  instruction in E is a load
- rdM, rdW  in  5  destinations in M and W
- regWriteM, regWriteW  in  1  M/W instruction writes the register file
- pcSrcE  in  1  branch or jump taken in E
- mduStartE  in  1  multi-cycle MDU op issued from E this cycle
- mduDone  in  1  MDU result valid this cycle
- imemReady  in  1  instruction memory returns valid instrF for pcF this cycle
- stallF, stallD, stallE  out  1  hold the PC, IF/ID and ID/EX registers
- flushD, flushE, flushM  out  1  insert a NOP into IF/ID, ID/EX and EX/MEM
- forwardAE, forwardBE  out  2  00 register file, 01 W result, 10 M ALU result
- stallCycles, flushCount  out  32  saturating performance counters

## Operation
- States: HOLD, RUN, MDU_WAIT. Reset enters HOLD with the hold counter at 0.
- HOLD: stallF=1, flushD=1, flushE=1; all other controls 0. After RESET_CYCLES cycles, go to RUN.
- RUN, evaluated in priority order. The first matching rule sets the outputs. Unlisted outputs are 0.
  1. pcSrcE: flushD=1, flushE=1, stallF=0. flushCount increments. This rule overrides load-use and imem wait.
  2. mduStartE && !mduDone: stallF=stallD=stallE=1, flushM=1. Go to MDU_WAIT. If mduStartE && mduDone, no stall and stay in RUN.
  3. Load-use: loadE && rdE!=0 && (rdE==rs1D || rdE==rs2D). Drive stallF=1, stallD=1, flushE=1, flushD=0. This rule applies even when imemReady=0.
  4. !imemReady: stallF=1, flushD=1, stallD=0.
- MDU_WAIT:
  - While !mduDone: stallF=stallD=stallE=1, flushM=1. pcSrcE is ignored.
  - On mduDone: all controls 0 and go to RUN. A new mduStartE is not accepted in this cycle.
- pcSrcE and mduStartE asserted together is illegal. If it happens, rule 1 wins and MDU_WAIT is not entered.
- Forwarding (combinational, every state):
  - forwardAE=10 if regWriteM && rdM!=0 && rdM==rs1E.
  - Otherwise forwardAE=01 if regWriteW && rdW!=0 && rdW==rs1E.
  - Otherwise forwardAE=00.
  - forwardBE uses the same rules with rs2E. M has priority over W.
- stallCycles increments in every RUN or MDU_WAIT cycle with stallF=1. It does not count in HOLD.
- Both counters saturate at 32'hFFFF_FFFF.

## Timing
- All stall, flush and forward outputs are combinational from the current state and inputs. They are valid in the same cycle and are sampled by the pipeline registers at the next posedge.
- State and counters update at posedge clk.
- rst asserted (asynchronous): immediately state=HOLD, hold counter=0, stallCycles=0, flushCount=0, stallF=flushD=flushE=1, and all other outputs 0 (forwards 00 given rd*=0).
- Reset mid-MDU_WAIT aborts the wait. The MDU is reset by the same rst.
- HOLD lasts exactly RESET_CYCLES cycles after the first posedge with rst=0.
- Load-use costs exactly one stall cycle. Taken branch costs two squashed instructions (D and E).
- The MDU stall lasts from the start cycle through the cycle before mduDone. E releases on the mduDone cycle.

## Test plan
- Reset release, RESET_CYCLES=2 → stallF/flushD/flushE=1 for 2 cycles, then all 0 with imemReady=1. stallCycles stays 0.
- lw x5 in E (loadE=1, rdE=5), rs1D=5 → one cycle of stallF=stallD=flushE=1. Repeat with rdE=0 → no stall.
- pcSrcE=1 with a load-use match and imemReady=0 at the same time → flushD=flushE=1, stallF=stallD=0. flushCount +1.
- mduStartE=1, then mduDone=1 three cycles later → stalls and flushM held for 3 cycles, released on the done cycle. stallCycles +3.
- imemReady=0 for 4 cycles in RUN → stallF=1 and flushD=1 each cycle, stallD=0. stallCycles +4.
- Forwarding: rdM=rdW=7, regWriteM=regWriteW=1, rs1E=7 → forwardAE=10. Drop regWriteM → 01. Set rdM=rdW=0 → 00.
